watchdog_timer_bank: RTL and testbench
======================================

Name: watchdog_timer_bank

Overview:
- Parametrised, multi-channel successor to the single fixed 1 s timeout timer.
- CHANNELS independent timeout counters share one prescaled tick.
- Each channel has a per-start programmable limit, kick (restart), stop, and one-shot or periodic mode.
- Used by block-RAM test harnesses and hash-pipeline supervisors to detect stalled units.

Parameters:
- WIDTH, 26, bit width of each channel counter and limit.
- CHANNELS, 4, number of independent timeout channels (1..32).
- PRESCALE, 1, clock cycles per tick (1 = tick every cycle; 50 = 1 us at 50 MHz).

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous active-low reset.
- start_i  in  CHANNELS  per-channel start/restart strobe.
- kick_i  in  CHANNELS  per-channel watchdog kick; restarts the count while running.
- stop_i  in  CHANNELS  per-channel stop; returns the channel to idle.
- periodic_i  in  CHANNELS  mode, sampled at start: 1 = periodic, 0 = one-shot.
- limit_i  in  CHANNELS*WIDTH  per-channel limit in ticks, sampled at start; channel n occupies bits [n*WIDTH +: WIDTH].
- running_o  out  CHANNELS  channel is in the RUN state.
- timed_out_o  out  CHANNELS  sticky expiry flag.
- expire_pulse_o  out  CHANNELS  one-cycle pulse on each expiry.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset_ni low, every register clears immediately: all outputs 0, all channels IDLE, counts 0, prescaler 0.
- Prescaler:
  - free-running 0..PRESCALE-1; tick is asserted in the cycle it equals PRESCALE-1.
  - not reset by start or kick, so the first tick after a start arrives 1..PRESCALE cycles later.
  - with PRESCALE=1, tick is constant 1.
- Per-channel FSM states: IDLE, RUN, EXPIRED.
- Command priority per channel: stop > start > kick > tick.
- stop (any state): go to IDLE, count=0, timed_out=0.
- start (any state):
  - latch limit and periodic, count=0, timed_out=0, go to RUN.
  - a same-cycle tick is ignored.
- kick: in RUN, count=0 and a same-cycle expiry is suppressed; in IDLE or EXPIRED, ignored.
- Tick in RUN:
  - if count+1 >= latched limit, the channel expires; otherwise count increments.
  - a latched limit of 0 or 1 expires on the first tick.
- Expiry:
  - expire_pulse_o is high for exactly one cycle and timed_out_o is set, both registered.
  - one-shot: go to EXPIRED and hold count at the limit.
  - periodic: count=0, stay in RUN; timed_out_o stays set until the next stop or start.
- Latency, PRESCALE=1, limit L>=1: start sampled at edge E0 gives expire_pulse_o and timed_out_o high after edge EL, i.e. L cycles later.
- Arithmetic: count+1 is evaluated at WIDTH+1 bits, so a limit of 2^WIDTH-1 never wraps.
- Channels are fully independent; simultaneous expiries on several channels all pulse in the same cycle.
- Reset mid-count aborts the count with no pulse emitted.

Optional Feature:
- Macro: WATCHDOG_TIMER_BANK_IRQ_EN.
- Defined: adds ports irq_mask_i (in, CHANNELS), irq_ack_i (in, 1) and irq_o (out, 1).
  - irq_o is a registered sticky OR of (expire_pulse & irq_mask_i).
  - irq_ack_i clears irq_o one cycle later; an expiry in the ack cycle wins and irq_o stays 1.
  - irq_o resets to 0.
- Undefined: these ports and their logic are absent; the core behaviour is identical.

Decomposition:
- Package watchdog_timer_pkg:
  - channel state enum (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2).
  - localparam for the prescaler width, $clog2(PRESCALE) with a minimum of 1.
- Sub-module watchdog_timer_channel: one FSM, counter, limit and mode latch.
  - instantiated CHANNELS times via generate, fed a shared tick.
- The prescaler and the IRQ aggregation stay in the top level.

Test Plan:
- Reset mid-run: with PRESCALE=1, start ch0 with limit 100; drop reset_ni at cycle 50 -> all outputs 0 asynchronously; no pulse after release.
- One-shot: with PRESCALE=1, start ch0 with limit 5 at E0 -> pulse exactly at E5 (one cycle); timed_out stays 1, running 0; kicks afterwards ignored.
- Kick: start ch1 with limit 10; kick at cycles 8 and 16 -> no expiry; expiry at cycle 26. A kick in the expiry cycle suppresses that pulse.
- Periodic: with PRESCALE=4, start ch2 periodic with limit 3 -> pulses every 12 cycles; first pulse within 9..12 cycles of start; timed_out stays 1; stop clears all.
- Priority: start+stop on the same cycle -> IDLE. Limit 0 and limit 1 expire on the first tick. Limit 2^26-1 with WIDTH=26 reaches the limit without wrap (force the count near the end).
- IRQ (macro defined): mask 4'b0101; expire ch1 -> irq_o stays 0; expire ch2 -> irq_o=1; irq_ack_i clears it; ack coincident with a ch0 expiry -> irq_o stays 1.

Source files
------------

// File: rtl/watchdog_timer_pkg.sv
// -----------------------------------------------------------------------------
// watchdog_timer_pkg
// Shared types and helpers for the watchdog timer bank.
//   chan_state_e  : per-channel FSM state (IDLE / RUN / EXPIRED)
//   presc_width() : prescaler counter width, $clog2(PRESCALE) but never below 1
// -----------------------------------------------------------------------------
package watchdog_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } chan_state_e;

    localparam int MIN_PRESC_W = 1;

    // A PRESCALE of 1 still needs a one-bit counter so the compare is legal.
    function automatic int presc_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < MIN_PRESC_W) ? MIN_PRESC_W : w;
    endfunction

endpackage

// File: rtl/watchdog_timer_channel.sv
// -----------------------------------------------------------------------------
// watchdog_timer_channel
// One timeout channel: FSM, tick counter, latched limit and latched mode.
// Ports:
//   clk_i, reset_ni   : clock, asynchronous active-low reset
//   tick_i            : shared prescaled tick
//   start_i           : latch limit/mode, clear count and flag, enter RUN
//   kick_i            : restart the count while in RUN
//   stop_i            : back to IDLE, clear count and flag
//   periodic_i        : mode sampled at start (1 = periodic, 0 = one-shot)
//   limit_i           : limit in ticks, sampled at start
//   state_o           : current FSM state (also used for debug visibility)
//   timed_out_o       : sticky expiry flag
//   expire_pulse_o    : one-cycle registered pulse on each expiry
// Command priority: stop > start > kick > tick.
// -----------------------------------------------------------------------------
module watchdog_timer_channel
    import watchdog_timer_pkg::*;
#(
    parameter int WIDTH = 26
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             kick_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [WIDTH-1:0] limit_i,
    output chan_state_e      state_o,
    output logic             timed_out_o,
    output logic             expire_pulse_o
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             periodic_q, periodic_d;
    logic             timed_out_q, timed_out_d;
    logic             pulse_q, pulse_d;

    // One extra bit so a limit of all-ones compares without wrapping.
    logic [WIDTH:0]   count_inc;
    assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        limit_d     = limit_q;
        periodic_d  = periodic_q;
        timed_out_d = timed_out_q;
        pulse_d     = 1'b0;

        if (stop_i) begin
            state_d     = IDLE;
            count_d     = '0;
            timed_out_d = 1'b0;
        end else if (start_i) begin
            // A tick arriving with the start is deliberately dropped.
            state_d     = RUN;
            count_d     = '0;
            limit_d     = limit_i;
            periodic_d  = periodic_i;
            timed_out_d = 1'b0;
        end else if (kick_i) begin
            // Kick outranks the tick, so an expiry in this cycle never fires.
            if (state_q == RUN) begin
                count_d = '0;
            end
        end else if (tick_i && (state_q == RUN)) begin
            // Limits 0 and 1 both satisfy this on the first tick.
            if (count_inc >= {1'b0, limit_q}) begin
                pulse_d     = 1'b1;
                timed_out_d = 1'b1;
                if (periodic_q) begin
                    count_d = '0;
                end else begin
                    state_d = EXPIRED;
                    count_d = limit_q;
                end
            end else begin
                count_d = count_inc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            limit_q     <= '0;
            periodic_q  <= 1'b0;
            timed_out_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            limit_q     <= limit_d;
            periodic_q  <= periodic_d;
            timed_out_q <= timed_out_d;
            pulse_q     <= pulse_d;
        end
    end

    assign state_o        = state_q;
    assign timed_out_o    = timed_out_q;
    assign expire_pulse_o = pulse_q;

endmodule

// File: rtl/watchdog_timer_bank.sv
// -----------------------------------------------------------------------------
// watchdog_timer_bank
// CHANNELS independent timeout channels sharing one prescaled tick.
// Parameters: WIDTH (counter/limit bits), CHANNELS (1..32),
//             PRESCALE (clock cycles per tick, 1 = every cycle).
// Ports:
//   clk_i, reset_ni    : clock, asynchronous active-low reset
//   start_i, kick_i,
//   stop_i, periodic_i : per-channel commands / mode (one bit per channel)
//   limit_i            : per-channel limit, channel n at [n*WIDTH +: WIDTH]
//   running_o          : channel is in RUN
//   timed_out_o        : sticky per-channel expiry flag
//   expire_pulse_o     : one-cycle pulse per expiry
// Optional (macro WATCHDOG_TIMER_BANK_IRQ_EN):
//   irq_mask_i, irq_ack_i, irq_o : sticky interrupt from masked expiries.
// Handshake: all command inputs are level strobes sampled on every rising
// clock edge; there is no valid/ready flow control on this block.
// -----------------------------------------------------------------------------
module watchdog_timer_bank
    import watchdog_timer_pkg::*;
#(
    parameter int WIDTH    = 26,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [CHANNELS-1:0]       start_i,
    input  logic [CHANNELS-1:0]       kick_i,
    input  logic [CHANNELS-1:0]       stop_i,
    input  logic [CHANNELS-1:0]       periodic_i,
    input  logic [CHANNELS*WIDTH-1:0] limit_i,
`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
    input  logic [CHANNELS-1:0]       irq_mask_i,
    input  logic                      irq_ack_i,
    output logic                      irq_o,
`endif
    output logic [CHANNELS-1:0]       running_o,
    output logic [CHANNELS-1:0]       timed_out_o,
    output logic [CHANNELS-1:0]       expire_pulse_o
);

    localparam int PRESC_W = presc_width(PRESCALE);

    // Free-running prescaler; start/kick do not touch it, so the first tick
    // after a start lands anywhere from 1 to PRESCALE cycles later.
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;

    always_comb begin
        tick    = (presc_q == PRESC_W'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    chan_state_e chan_state [CHANNELS];

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        watchdog_timer_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk_i          (clk_i),
            .reset_ni       (reset_ni),
            .tick_i         (tick),
            .start_i        (start_i[n]),
            .kick_i         (kick_i[n]),
            .stop_i         (stop_i[n]),
            .periodic_i     (periodic_i[n]),
            .limit_i        (limit_i[n*WIDTH +: WIDTH]),
            .state_o        (chan_state[n]),
            .timed_out_o    (timed_out_o[n]),
            .expire_pulse_o (expire_pulse_o[n])
        );

        assign running_o[n] = (chan_state[n] == RUN);
    end

`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
    // Sourced from the registered expiry pulses, so irq_o rises the cycle
    // after expire_pulse_o; a pulse visible during an ack cycle keeps it set.
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (|(expire_pulse_o & irq_mask_i)) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_watchdog_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_watchdog_timer_bank
// Two DUT instances (PRESCALE 1 and 4) share one stimulus stream. A
// behavioural model tracks elapsed ticks per channel and is compared with
// both instances on every falling edge; directed sections add literal
// latency/flag checks.
// -----------------------------------------------------------------------------
module tb_watchdog_timer_bank;

    localparam int W  = 26;
    localparam int CH = 4;

    logic clk_i    = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [CH-1:0]   start_i, kick_i, stop_i, periodic_i;
    logic [CH*W-1:0] limit_i;
    logic [CH-1:0]   run1, to1, pl1, run4, to4, pl4;
`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
    logic [CH-1:0]   irq_mask_i;
    logic            irq_ack_i;
    logic            irq1, irq4;
`endif

    watchdog_timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(1)) dut_p1 (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .kick_i         (kick_i),
        .stop_i         (stop_i),
        .periodic_i     (periodic_i),
        .limit_i        (limit_i),
`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
        .irq_mask_i     (irq_mask_i),
        .irq_ack_i      (irq_ack_i),
        .irq_o          (irq1),
`endif
        .running_o      (run1),
        .timed_out_o    (to1),
        .expire_pulse_o (pl1)
    );

    watchdog_timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(4)) dut_p4 (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .kick_i         (kick_i),
        .stop_i         (stop_i),
        .periodic_i     (periodic_i),
        .limit_i        (limit_i),
`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
        .irq_mask_i     (irq_mask_i),
        .irq_ack_i      (irq_ack_i),
        .irq_o          (irq4),
`endif
        .running_o      (run4),
        .timed_out_o    (to4),
        .expire_pulse_o (pl4)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit     active;   // counting ticks
        longint elapsed;  // ticks since last start/kick/periodic expiry
        longint lim;
        bit     per;
        bit     timed;
        bit     pulse;
    } mch_t;

    mch_t mdl [2][CH];
    int   presc [2];
    bit   irq_m [2];

    function automatic int ps(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    always @(posedge clk_i or negedge reset_ni) begin
        bit tick;
        bit irq_hit;
        if (!reset_ni) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) mdl[d][c] = '{default: 0};
                presc[d] = 0;
                irq_m[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                tick     = (presc[d] == ps(d) - 1);
                presc[d] = (presc[d] + 1) % ps(d);
                irq_hit  = 1'b0;
`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
                for (int c = 0; c < CH; c++)
                    if (mdl[d][c].pulse && irq_mask_i[c]) irq_hit = 1'b1;
                if (irq_hit) irq_m[d] = 1'b1;
                else if (irq_ack_i) irq_m[d] = 1'b0;
`endif
                for (int c = 0; c < CH; c++) begin
                    mdl[d][c].pulse = 1'b0;
                    if (stop_i[c]) begin
                        mdl[d][c].active  = 1'b0;
                        mdl[d][c].elapsed = 0;
                        mdl[d][c].timed   = 1'b0;
                    end else if (start_i[c]) begin
                        mdl[d][c].active  = 1'b1;
                        mdl[d][c].elapsed = 0;
                        mdl[d][c].timed   = 1'b0;
                        mdl[d][c].lim     = longint'(limit_i[c*W +: W]);
                        mdl[d][c].per     = periodic_i[c];
                    end else if (kick_i[c]) begin
                        if (mdl[d][c].active) mdl[d][c].elapsed = 0;
                    end else if (tick && mdl[d][c].active) begin
                        mdl[d][c].elapsed++;
                        if (mdl[d][c].elapsed >= mdl[d][c].lim) begin
                            mdl[d][c].pulse = 1'b1;
                            mdl[d][c].timed = 1'b1;
                            if (mdl[d][c].per) mdl[d][c].elapsed = 0;
                            else mdl[d][c].active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [CH-1:0] exp_vec(input int d, input int which);
        logic [CH-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            case (which)
                0:       v[c] = mdl[d][c].active;
                1:       v[c] = mdl[d][c].timed;
                default: v[c] = mdl[d][c].pulse;
            endcase
        end
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        check("p1_running",   longint'(run1), longint'(exp_vec(0, 0)));
        check("p1_timed_out", longint'(to1),  longint'(exp_vec(0, 1)));
        check("p1_pulse",     longint'(pl1),  longint'(exp_vec(0, 2)));
        check("p4_running",   longint'(run4), longint'(exp_vec(1, 0)));
        check("p4_timed_out", longint'(to4),  longint'(exp_vec(1, 1)));
        check("p4_pulse",     longint'(pl4),  longint'(exp_vec(1, 2)));
`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
        check("p1_irq", longint'(irq1), longint'(irq_m[0]));
        check("p4_irq", longint'(irq4), longint'(irq_m[1]));
`endif
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic set_lim(input int c, input longint v);
        limit_i[c*W +: W] = W'(v);
    endtask

    // Returns at the falling edge after the start edge E0.
    task automatic strobe_start(input logic [CH-1:0] m, input logic [CH-1:0] per);
        start_i    = m;
        periodic_i = per;
        @(negedge clk_i);
        start_i    = '0;
    endtask

    task automatic stop_all();
        stop_i = '1;
        @(negedge clk_i);
        stop_i = '0;
    endtask

    function automatic logic [CH-1:0] get_pl(input int d);
        return (d == 0) ? pl1 : pl4;
    endfunction

    // lat = k when the pulse is seen after edge Ek (E0 = start edge).
    task automatic wait_pulse(input int d, input int c, input int budget, output int lat);
        logic [CH-1:0] p;
        lat = 0;
        p   = get_pl(d);
        while (!p[c] && lat < budget) begin
            @(negedge clk_i);
            lat++;
            p = get_pl(d);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat, first, p1, p2, cnt;
        start_i    = '0;
        kick_i     = '0;
        stop_i     = '0;
        periodic_i = '0;
        limit_i    = '0;
`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
        irq_mask_i = '0;
        irq_ack_i  = 1'b0;
`endif
        repeat (3) @(negedge clk_i);
        check("reset_outputs", longint'({run1, to1, pl1, run4, to4, pl4}), 0);
        reset_ni = 1'b1;

        // One-shot, limit 5: pulse after E5, one cycle wide, kicks ignored.
        set_lim(0, 5);
        strobe_start(4'b0001, 4'b0000);
        wait_pulse(0, 0, 20, lat);
        check("oneshot_latency", lat, 5);
        @(negedge clk_i);
        check("oneshot_pulse_width", longint'(pl1[0]), 0);
        kick_i = 4'b0001;
        @(negedge clk_i);
        kick_i = '0;
        @(negedge clk_i);
        check("oneshot_timed_out_held", longint'(to1[0]), 1);
        check("oneshot_not_running", longint'(run1[0]), 0);
        stop_all();

        // Kick at E8 and E16 with limit 10: expiry at E26.
        set_lim(1, 10);
        strobe_start(4'b0010, 4'b0000);
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            kick_i = (k == 8 || k == 16) ? 4'b0010 : 4'b0000;
            @(negedge clk_i);
            if (pl1[1] && first == 0) first = k;
        end
        kick_i = '0;
        check("kick_delays_expiry", first, 26);
        stop_all();

        // Kick on the expiry edge E10 suppresses it: next expiry at E20.
        strobe_start(4'b0010, 4'b0000);
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            kick_i = (k == 10) ? 4'b0010 : 4'b0000;
            @(negedge clk_i);
            if (pl1[1] && first == 0) first = k;
        end
        kick_i = '0;
        check("kick_suppresses_pulse", first, 20);
        stop_all();

        // Periodic limit 3 on ch2; PRESCALE 4 instance pulses every 12.
        set_lim(2, 3);
        strobe_start(4'b0100, 4'b0100);
        p1 = 0;
        p2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (pl4[2]) begin
                if (p1 == 0) p1 = k;
                else if (p2 == 0) p2 = k;
            end
        end
        check("periodic_first_in_9_12", longint'(p1 >= 9 && p1 <= 12), 1);
        check("periodic_gap_12", p2 - p1, 12);
        check("periodic_timed_out_sticky", longint'(to4[2]), 1);
        check("periodic_still_running", longint'(run4[2]), 1);
        stop_i = 4'b0100;
        @(negedge clk_i);
        stop_i = '0;
        check("stop_clears", longint'({to1[2], run1[2], to4[2], run4[2]}), 0);

        // Start and stop together: stop wins.
        start_i = 4'b1000;
        stop_i  = 4'b1000;
        @(negedge clk_i);
        start_i = '0;
        stop_i  = '0;
        check("stop_beats_start", longint'(run1[3]), 0);

        // Limits 0 and 1 both expire on the first tick, in the same cycle.
        set_lim(0, 0);
        set_lim(3, 1);
        strobe_start(4'b1001, 4'b0000);
        @(negedge clk_i);
        check("limit_0_1_first_tick", longint'(pl1), longint'(4'b1001));
        stop_all();

        // Maximum limit: jump the count close to the end, no wrap.
        set_lim(0, (longint'(1) << W) - 1);
        strobe_start(4'b0001, 4'b0000);
        force dut_p1.g_chan[0].u_chan.count_q = W'((longint'(1) << W) - 4);
        mdl[0][0].elapsed = (longint'(1) << W) - 4;
        #1;
        release dut_p1.g_chan[0].u_chan.count_q;
        wait_pulse(0, 0, 10, lat);
        check("max_limit_latency", lat, 3);
        @(negedge clk_i);
        check("max_limit_timed_out", longint'(to1[0]), 1);
        check("max_limit_stopped", longint'(run1[0]), 0);
        stop_all();

        // Reset mid-run: outputs clear asynchronously, no later pulse.
        set_lim(0, 100);
        strobe_start(4'b0001, 4'b0000);
        repeat (50) @(negedge clk_i);
        check("running_before_reset", longint'(run1[0]), 1);
        @(posedge clk_i);
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_reset_clear", longint'({run1, to1, pl1, run4, to4, pl4}), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        cnt = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk_i);
            if (pl1[0] || pl4[0]) cnt++;
        end
        check("no_pulse_after_reset", cnt, 0);

`ifdef WATCHDOG_TIMER_BANK_IRQ_EN
        irq_mask_i = 4'b0101;
        set_lim(1, 2);
        strobe_start(4'b0010, 4'b0000);
        repeat (4) @(negedge clk_i);
        check("irq_masked_channel", longint'(irq1), 0);
        set_lim(2, 2);
        strobe_start(4'b0100, 4'b0000);
        repeat (4) @(negedge clk_i);
        check("irq_set", longint'(irq1), 1);
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        check("irq_ack_clears", longint'(irq1), 0);
        set_lim(0, 3);
        strobe_start(4'b0001, 4'b0000);
        repeat (3) @(negedge clk_i);
        check("irq_pulse_visible", longint'(pl1[0]), 1);
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        check("irq_expiry_beats_ack", longint'(irq1), 1);
`endif

        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
